// File: rtl/icache_if.sv
// Fetch-side and memory-side signals of the instruction cache controller.
// Slave is the cache controller; master is the fetch stage plus instruction memory.
interface icache_if #(
  parameter int unsigned WORD_SIZE  = 32,
  parameter int unsigned BLOCK_SIZE = 16
);
  logic                            cpu_req;
  logic [WORD_SIZE-1:0]            cpu_addr;
  logic                            cpu_ready;
  logic                            cpu_valid;
  logic [WORD_SIZE-1:0]            cpu_inst;
  logic                            flush;
  logic [WORD_SIZE-1:0]            mem_ptr;
  logic [WORD_SIZE*BLOCK_SIZE-1:0] mem_block;

  modport slave (
    input  cpu_req, cpu_addr, flush, mem_block,
    output cpu_ready, cpu_valid, cpu_inst, mem_ptr
  );

  modport master (
    output cpu_req, cpu_addr, flush, mem_block,
    input  cpu_ready, cpu_valid, cpu_inst, mem_ptr
  );
endinterface

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller: single-cycle hits from line storage,
// misses fetch the aligned 16-word block after a fixed memory latency.
module icache_ctrl #(
  parameter int unsigned WORD_SIZE   = 32,
  parameter int unsigned BLOCK_SIZE  = 16,
  parameter int unsigned NUM_LINES   = 8,
  parameter int unsigned MEM_LATENCY = 4
) (
  input  logic        clk,
  input  logic        reset,
  icache_if.slave     bus,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);
  localparam int unsigned OFF_W   = 4;
  localparam int unsigned INDEX_W = $clog2(NUM_LINES);
  localparam int unsigned TAG_W   = WORD_SIZE - OFF_W - INDEX_W;
  localparam int unsigned CNT_W   = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  typedef enum logic [1:0] {StIdle, StRefill, StRespond} state_e;

  state_e               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [WORD_SIZE-1:0] addr_q;
  logic [WORD_SIZE-1:0] mem_ptr_q;
  logic [WORD_SIZE-1:0] cpu_inst_q;
  logic                 cpu_valid_q;
  logic                 cpu_ready_q;
  logic [31:0]          hit_q;
  logic [31:0]          miss_q;
  logic [NUM_LINES-1:0] valid_q;

  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [WORD_SIZE-1:0] data_q [NUM_LINES][BLOCK_SIZE];

  logic [WORD_SIZE-1:0] blk_words [BLOCK_SIZE];

  logic [OFF_W-1:0]   req_off, fill_off;
  logic [INDEX_W-1:0] req_idx, fill_idx;
  logic [TAG_W-1:0]   req_tag, fill_tag;
  logic               hit;
  logic               fill_en;

  // Word 0 of the memory block sits in the most significant slice.
  for (genvar i = 0; i < BLOCK_SIZE; i++) begin : g_unpack
    assign blk_words[i] = bus.mem_block[WORD_SIZE*(BLOCK_SIZE-i)-1 -: WORD_SIZE];
  end

  assign req_off  = bus.cpu_addr[OFF_W-1:0];
  assign req_idx  = bus.cpu_addr[OFF_W +: INDEX_W];
  assign req_tag  = bus.cpu_addr[WORD_SIZE-1 -: TAG_W];
  assign fill_off = addr_q[OFF_W-1:0];
  assign fill_idx = addr_q[OFF_W +: INDEX_W];
  assign fill_tag = addr_q[WORD_SIZE-1 -: TAG_W];

  assign hit     = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign fill_en = (state_q == StRefill) && (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (!reset && fill_en) begin
      tag_q[fill_idx] <= fill_tag;
      for (int i = 0; i < BLOCK_SIZE; i++) begin
        data_q[fill_idx][i] <= blk_words[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      addr_q      <= '0;
      mem_ptr_q   <= '0;
      cpu_inst_q  <= '0;
      cpu_valid_q <= 1'b0;
      cpu_ready_q <= 1'b1;
      hit_q       <= '0;
      miss_q      <= '0;
      valid_q     <= '0;
    end else begin
      cpu_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.cpu_req) begin
            addr_q <= bus.cpu_addr;
            if (hit) begin
              cpu_valid_q <= 1'b1;
              cpu_inst_q  <= data_q[req_idx][req_off];
              hit_q       <= hit_q + 32'd1;
            end else begin
              miss_q      <= miss_q + 32'd1;
              mem_ptr_q   <= {bus.cpu_addr[WORD_SIZE-1:OFF_W], {OFF_W{1'b0}}};
              cnt_q       <= CNT_W'(MEM_LATENCY - 1);
              cpu_ready_q <= 1'b0;
              state_q     <= StRefill;
            end
          end
        end
        StRefill: begin
          if (cnt_q == '0) begin
            valid_q[fill_idx] <= 1'b1;
            cpu_valid_q       <= 1'b1;
            cpu_inst_q        <= blk_words[fill_off];
            state_q           <= StRespond;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        StRespond: begin
          cpu_ready_q <= 1'b1;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
      // Flush wins over a same-edge fill: the line data lands but stays invalid.
      if (bus.flush) begin
        valid_q <= '0;
      end
    end
  end

  assign bus.cpu_ready = cpu_ready_q;
  assign bus.cpu_valid = cpu_valid_q;
  assign bus.cpu_inst  = cpu_inst_q;
  assign bus.mem_ptr   = mem_ptr_q;
  assign hit_count     = hit_q;
  assign miss_count    = miss_q;
endmodule
